// File: rtl/sap_1_program_loader.sv
// sap_1_program_loader: the writer side of the SAP-1 16x8 program memory.
// It takes a byte stream over a valid/ready handshake and writes the bytes to
// addresses 0..WORDS-1 in order. The CPU is held in clear until the load has
// finished, and for one further cycle after the last write.
//
// Optional feature: define SAP_1_LOADER_CHECKSUM_EN to add a trailing checksum
// byte. The mod-256 sum of all WORDS+1 bytes must be zero, or the loader ends
// in ERROR. When the macro is undefined, err is tied to 0.
//
// Ports
//   Clk, Clrbar           clock, asynchronous active-low reset
//   start                 begin a load (sampled in IDLE, DONE, ERROR)
//   byte_in, byte_valid   incoming program byte and its valid
//   byte_ready            loader accepts byte_in this cycle
//   mem_addr, mem_data    program-memory write address and data
//   mem_we                one-cycle write strobe per byte
//   cpu_clr               active-high CPU clear
//   busy, done, err       status: LOAD/WRITE/RELEASE(/CHECK), DONE, ERROR
//   count                 bytes written since the last start, 0..WORDS
module sap_1_program_loader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WORDS  = 16
) (
    input  logic              Clk,
    input  logic              Clrbar,
    input  logic              start,
    input  logic [DATA_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              cpu_clr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned       CNT_W    = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WRITE   = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4,
        S_CHECK   = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_byte_ready;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_mem_we;
    logic              r_cpu_clr;
    logic              r_busy;
    logic              r_done;
    logic              w_start_ok;

    assign byte_ready = r_byte_ready;
    assign mem_addr   = r_mem_addr;
    assign mem_data   = r_mem_data;
    assign mem_we     = r_mem_we;
    assign cpu_clr    = r_cpu_clr;
    assign busy       = r_busy;
    assign done       = r_done;
    assign count      = r_count;

`ifdef SAP_1_LOADER_CHECKSUM_EN
    logic              r_err;
    logic [DATA_W-1:0] r_sum;
    logic [DATA_W-1:0] w_sum_next;

    assign err        = r_err;
    // Running sum including the byte offered this cycle.
    assign w_sum_next = r_sum + byte_in;
    assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE ||
                                  r_state == S_ERROR);
`else
    assign err        = 1'b0;
    assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
`endif

    // Loader FSM; every output is registered alongside the state transition.
    always_ff @(posedge Clk or negedge Clrbar) begin
        if (!Clrbar) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_count      <= '0;
            r_byte_ready <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_mem_we     <= 1'b0;
            r_cpu_clr    <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef SAP_1_LOADER_CHECKSUM_EN
            r_err        <= 1'b0;
            r_sum        <= '0;
`endif
        end else if (w_start_ok) begin
            r_state      <= S_LOAD;
            r_ptr        <= '0;
            r_count      <= '0;
            r_byte_ready <= 1'b1;
            r_cpu_clr    <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
`ifdef SAP_1_LOADER_CHECKSUM_EN
            r_err        <= 1'b0;
            r_sum        <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                end
                S_LOAD: begin
                    if (byte_valid) begin
                        r_state      <= S_WRITE;
                        r_mem_addr   <= r_ptr;
                        r_mem_data   <= byte_in;
                        r_mem_we     <= 1'b1;
                        r_byte_ready <= 1'b0;
`ifdef SAP_1_LOADER_CHECKSUM_EN
                        r_sum        <= w_sum_next;
`endif
                    end
                end
                S_WRITE: begin
                    r_mem_we <= 1'b0;
                    r_count  <= r_count + CNT_W'(1);
                    if (r_ptr == LAST_PTR) begin
`ifdef SAP_1_LOADER_CHECKSUM_EN
                        r_state      <= S_CHECK;
                        r_byte_ready <= 1'b1;
`else
                        r_state      <= S_RELEASE;
`endif
                    end else begin
                        r_ptr        <= r_ptr + ADDR_W'(1);
                        r_state      <= S_LOAD;
                        r_byte_ready <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    r_state   <= S_DONE;
                    r_cpu_clr <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                end
`ifdef SAP_1_LOADER_CHECKSUM_EN
                // Checksum byte is consumed but never written to memory.
                S_CHECK: begin
                    if (byte_valid) begin
                        r_byte_ready <= 1'b0;
                        r_sum        <= w_sum_next;
                        if (w_sum_next == '0) begin
                            r_state <= S_RELEASE;
                        end else begin
                            r_state <= S_ERROR;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_ERROR: begin
                end
`endif
                default: begin
                    r_state      <= S_IDLE;
                    r_mem_we     <= 1'b0;
                    r_byte_ready <= 1'b0;
                    r_cpu_clr    <= 1'b1;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sap_1_program_loader.sv
// Directed self-checking bench for sap_1_program_loader. It supports both the
// default build and the SAP_1_LOADER_CHECKSUM_EN build.
module tb_sap_1_program_loader;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WORDS  = 16;
`ifdef SAP_1_LOADER_CHECKSUM_EN
    localparam int N_BYTES  = 17;
    localparam int DONE_LAT = 3;   // WRITE -> CHECK -> RELEASE -> DONE
`else
    localparam int N_BYTES  = 16;
    localparam int DONE_LAT = 2;   // WRITE -> RELEASE -> DONE
`endif

    logic              Clk = 1'b0;
    logic              Clrbar;
    logic              start;
    logic [DATA_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_we;
    logic              cpu_clr;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] bytes [0:16];
    int  wr_addr[$];
    int  wr_data[$];
    int  wr_cyc[$];
    int  n_acc;
    int  end_cyc;
    bit  clr_low_seen;

    sap_1_program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) dut (
        .Clk(Clk), .Clrbar(Clrbar), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_we(mem_we), .cpu_clr(cpu_clr), .busy(busy),
        .done(done), .err(err), .count(count)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Load a stream: byte i = base + i*step, with byte 16 as the zero-sum checksum.
    task automatic fill(input logic [7:0] base, input logic [7:0] step);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 16; i++) begin
            bytes[i] = base + 8'(i) * step;
            s        = s + bytes[i];
        end
        bytes[16] = 8'h00 - s;
    endtask

    // Feeds the stream and records every write until done/err, abort, or timeout.
    // mode 0: valid held; mode 1: valid raised on 1-of-3 cycles and held until taken.
    task automatic drive(input int mode, input int abort_at, input int start_at);
        int idx;
        int c;
        bit acc;
        int hold;
        bit fired;
        idx = 0; c = 0; hold = 0; fired = 0;
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        clr_low_seen = 0;
        while (c < 400) begin
            if (mem_we) begin
                wr_addr.push_back(int'(mem_addr));
                wr_data.push_back(int'(mem_data));
                wr_cyc.push_back(c);
            end
            if (done || err) break;
            if (!cpu_clr) clr_low_seen = 1;
            if (abort_at > 0 && wr_addr.size() == abort_at) break;
            if (start_at > 0 && !fired && wr_addr.size() == start_at) begin
                fired = 1;
                hold  = 3;
            end
            start = (hold > 0);
            if (hold > 0) hold--;
            if (idx < N_BYTES) begin
                byte_in = bytes[idx];
                if (mode == 0) byte_valid = 1'b1;
                else if (!byte_valid) byte_valid = (c % 3 == 0);
            end else begin
                byte_valid = 1'b0;
            end
            acc = byte_valid && byte_ready;
            tick();
            c++;
            if (acc) begin
                idx++;
                if (mode != 0) byte_valid = 1'b0;
            end
        end
        start      = 1'b0;
        byte_valid = 1'b0;
        n_acc      = idx;
        end_cyc    = c;
    endtask

    task automatic test_reset();
        Clrbar = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        repeat (3) tick();
        n_checks++;
        if ({cpu_clr, mem_we, busy, done, err, byte_ready} !== 6'b100000)
            $display("FAIL reset_flags: got %b want 100000",
                     {cpu_clr, mem_we, busy, done, err, byte_ready});
        else n_pass++;
        n_checks++;
        if ({count, mem_addr, mem_data} !== 17'd0)
            $display("FAIL reset_regs: count=%0d addr=%0d data=%h want 0", count, mem_addr, mem_data);
        else n_pass++;
        #2 Clrbar = 1'b1;
        tick();
        n_checks++;
        if ({cpu_clr, busy, done, byte_ready} !== 4'b1000)
            $display("FAIL idle_after_reset: got %b want 1000", {cpu_clr, busy, done, byte_ready});
        else n_pass++;
    endtask

    task automatic test_full_load();
        int bad;
        fill(8'h00, 8'h00);
        bytes[0] = 8'h09; bytes[1] = 8'h1A; bytes[2] = 8'h2B; bytes[3] = 8'hE0; bytes[4] = 8'hF0;
        bytes[16] = 8'hE2;
        pulse_start();
        n_checks++;
        if ({cpu_clr, busy, byte_ready, done, count} !== {4'b1110, 5'd0})
            $display("FAIL load_entry: flags=%b count=%0d want 1110/0", {cpu_clr, busy, byte_ready, done}, count);
        else n_pass++;
        drive(0, 0, 0);
        n_checks++;
        if (wr_addr.size() !== 16) $display("FAIL full_nwrites: got %0d want 16", wr_addr.size());
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (i >= wr_addr.size() || wr_addr[i] !== i || wr_data[i] !== int'(bytes[i]))
                $display("FAIL full_write%0d: addr=%0d data=%h want %0d/%h", i,
                         (i < wr_addr.size()) ? wr_addr[i] : -1,
                         (i < wr_data.size()) ? wr_data[i] : -1, i, bytes[i]);
            else n_pass++;
        end
        bad = 0;
        for (int i = 1; i < wr_cyc.size(); i++) if (wr_cyc[i] - wr_cyc[i-1] != 2) bad++;
        n_checks++;
        if (bad !== 0) $display("FAIL full_spacing: %0d gaps not equal to 2", bad);
        else n_pass++;
        n_checks++;
        if (wr_cyc.size() != 16 || end_cyc !== wr_cyc[15] + DONE_LAT)
            $display("FAIL release_latency: done at %0d want last write + %0d", end_cyc, DONE_LAT);
        else n_pass++;
        n_checks++;
        if (clr_low_seen !== 1'b0) $display("FAIL clr_during_load: cpu_clr dropped got 1 want 0");
        else n_pass++;
        n_checks++;
        if ({done, cpu_clr, busy, err, byte_ready, mem_we, count} !== {6'b100000, 5'd16})
            $display("FAIL done_state: flags=%b count=%0d want 100000/16",
                     {done, cpu_clr, busy, err, byte_ready, mem_we}, count);
        else n_pass++;
    endtask

`ifdef SAP_1_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        fill(8'h11, 8'h05);
        bytes[16] = bytes[16] + 8'h01;
        pulse_start();
        drive(0, 0, 0);
        n_checks++;
        if ({err, cpu_clr, done, busy, byte_ready} !== 5'b11000)
            $display("FAIL cks_error: flags=%b want 11000", {err, cpu_clr, done, busy, byte_ready});
        else n_pass++;
        n_checks++;
        if (wr_addr.size() !== 16 || count !== 5'd16)
            $display("FAIL cks_no17th: writes=%0d count=%0d want 16/16", wr_addr.size(), count);
        else n_pass++;
        pulse_start();
        n_checks++;
        if ({busy, err, cpu_clr, byte_ready} !== 4'b1011)
            $display("FAIL cks_restart: got %b want 1011", {busy, err, cpu_clr, byte_ready});
        else n_pass++;
        fill(8'h11, 8'h05);
        drive(0, 0, 0);
        n_checks++;
        if ({done, err, count} !== {2'b10, 5'd16})
            $display("FAIL cks_good: done=%b err=%b count=%0d want 1/0/16", done, err, count);
        else n_pass++;
    endtask
`else
    task automatic test_extra_byte();
        byte_in = 8'h55; byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({byte_ready, mem_we, done, count} !== {3'b001, 5'd16})
                $display("FAIL extra_byte%0d: ready/we/done=%b count=%0d want 001/16", i,
                         {byte_ready, mem_we, done}, count);
            else n_pass++;
        end
        byte_valid = 1'b0;
    endtask
`endif

    task automatic test_back_to_back();
        int bad;
        pulse_start();
        n_checks++;
        if ({cpu_clr, busy, done, byte_ready, count} !== {4'b1101, 5'd0})
            $display("FAIL restart_from_done: flags=%b count=%0d want 1101/0",
                     {cpu_clr, busy, done, byte_ready}, count);
        else n_pass++;
        fill(8'h03, 8'h07);
        drive(0, 0, 0);
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++)
            if (wr_addr[i] != i || wr_data[i] != int'(bytes[i])) bad++;
        n_checks++;
        if (wr_addr.size() !== 16 || bad !== 0)
            $display("FAIL reload: writes=%0d bad=%0d want 16/0", wr_addr.size(), bad);
        else n_pass++;
        n_checks++;
        if ({done, count} !== {1'b1, 5'd16}) $display("FAIL reload_done: done=%b count=%0d want 1/16", done, count);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int bad;
        fill(8'h30, 8'h01);
        pulse_start();
        drive(1, 0, 0);
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++)
            if (wr_addr[i] != i || wr_data[i] != int'(bytes[i])) bad++;
        n_checks++;
        if (wr_addr.size() !== 16 || bad !== 0)
            $display("FAIL bp_writes: writes=%0d bad=%0d want 16/0", wr_addr.size(), bad);
        else n_pass++;
        n_checks++;
        if (n_acc !== N_BYTES) $display("FAIL bp_accepted: got %0d want %0d", n_acc, N_BYTES);
        else n_pass++;
        n_checks++;
        if ({done, count} !== {1'b1, 5'd16}) $display("FAIL bp_done: done=%b count=%0d want 1/16", done, count);
        else n_pass++;
    endtask

    task automatic test_start_busy();
        int bad;
        fill(8'hA0, 8'h0B);
        pulse_start();
        drive(0, 0, 7);
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++)
            if (wr_addr[i] != i || wr_data[i] != int'(bytes[i])) bad++;
        n_checks++;
        if (wr_addr.size() !== 16 || bad !== 0)
            $display("FAIL busy_start_writes: writes=%0d bad=%0d want 16/0", wr_addr.size(), bad);
        else n_pass++;
        n_checks++;
        if (wr_cyc.size() != 16 || end_cyc !== wr_cyc[15] + DONE_LAT || count !== 5'd16)
            $display("FAIL busy_start_done: end=%0d count=%0d want last+%0d/16", end_cyc, count, DONE_LAT);
        else n_pass++;
    endtask

    task automatic test_abort();
        fill(8'h40, 8'h02);
        pulse_start();
        drive(0, 5, 0);
        n_checks++;
        if (wr_addr.size() !== 5 || mem_we !== 1'b1 || count !== 5'd4)
            $display("FAIL abort_pre: writes=%0d we=%b count=%0d want 5/1/4", wr_addr.size(), mem_we, count);
        else n_pass++;
        Clrbar = 1'b0;
        #1;
        n_checks++;
        if ({cpu_clr, mem_we, busy, done, byte_ready, count} !== {5'b10000, 5'd0})
            $display("FAIL abort_reset: flags=%b count=%0d want 10000/0",
                     {cpu_clr, mem_we, busy, done, byte_ready}, count);
        else n_pass++;
        #2 Clrbar = 1'b1;
        tick();
        fill(8'h90, 8'h03);
        pulse_start();
        drive(0, 0, 0);
        n_checks++;
        if (wr_addr.size() !== 16 || wr_addr[0] !== 0 || wr_data[0] !== int'(bytes[0]))
            $display("FAIL abort_reload: writes=%0d first_addr=%0d want 16/0", wr_addr.size(),
                     (wr_addr.size() > 0) ? wr_addr[0] : -1);
        else n_pass++;
        n_checks++;
        if ({done, count} !== {1'b1, 5'd16}) $display("FAIL abort_done: done=%b count=%0d want 1/16", done, count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_load();
`ifdef SAP_1_LOADER_CHECKSUM_EN
        test_checksum();
`else
        test_extra_byte();
`endif
        test_back_to_back();
        test_backpressure();
        test_start_busy();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
